// File: rtl/mux6to1_rr_ctrl_pkg.sv
// Shared constants, state type and select encoder for the 6:1 round-robin output arbiter.
package noc_arb_pkg;

    localparam int unsigned N_IN  = 6;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_A = 3'b000;
    localparam logic [SEL_W-1:0] SEL_B = 3'b001;
    localparam logic [SEL_W-1:0] SEL_C = 3'b010;
    localparam logic [SEL_W-1:0] SEL_D = 3'b011;
    localparam logic [SEL_W-1:0] SEL_E = 3'b100;
    localparam logic [SEL_W-1:0] SEL_F = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // One-hot grant to mux select; an all-zero grant encodes as SEL_A.
    function automatic logic [SEL_W-1:0] onehot6_to_sel(input logic [N_IN-1:0] g);
        logic [SEL_W-1:0] s;
        s = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (g[i]) s = s | SEL_W'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/mux6to1_rr_ctrl_if.sv
// Request/grant/handshake bundle between the input buffers, the arbiter and the output stage.
interface mux6to1_rr_ctrl_if;
    import noc_arb_pkg::*;

    logic [N_IN-1:0]  req;
    logic [N_IN-1:0]  tail;
    logic             out_ready;
    logic [N_IN-1:0]  gnt;
    logic [SEL_W-1:0] sel;
    logic             out_valid;
    logic [N_IN-1:0]  pop;
    logic             busy;

    // Arbiter side.
    modport slave (
        input  req, tail, out_ready,
        output gnt, sel, out_valid, pop, busy
    );

    // Buffer/downstream side.
    modport master (
        output req, tail, out_ready,
        input  gnt, sel, out_valid, pop, busy
    );
endinterface

// File: rtl/mux6to1_rr_ctrl_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 5 -> 0.
module rr_pick6
    import noc_arb_pkg::*;
(
    input  logic [N_IN-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N_IN-1:0]  win_o,
    output logic             any_o
);
    logic [N_IN-1:0]   rot;
    logic [N_IN-1:0]   rot_win;
    logic [2*N_IN-1:0] unrot;

    // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot     = N_IN'({req_i, req_i} >> ptr_i);
        rot_win = rot & (~rot + N_IN'(1));
        unrot   = {{N_IN{1'b0}}, rot_win} << ptr_i;
        win_o   = unrot[N_IN-1:0] | unrot[2*N_IN-1:N_IN];
        any_o   = |req_i;
    end
endmodule

// File: rtl/mux6to1_rr_ctrl.sv
// Packet-locking round-robin arbiter driving a shared 6:1 output mux and popping the winning buffer.
module mux6to1_rr_ctrl
    import noc_arb_pkg::*;
#(
    parameter bit          LOCK_EN  = 1'b1,
    parameter int unsigned PTR_INIT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux6to1_rr_ctrl_if.slave      arb
);
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(PTR_INIT);

    state_t           state_q, state_d;
    logic [N_IN-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             owner_req;
    logic             xfer;
    logic             release_now;
    logic [SEL_W-1:0] ptr_rel;
    logic [N_IN-1:0]  pick_req;
    logic [SEL_W-1:0] pick_ptr;
    logic [N_IN-1:0]  pick_win;
    logic             pick_any;

    // Handshake decode from the registered owner and the live request/ready inputs.
    always_comb begin
        owner_req   = |(arb.req & gnt_q);
        arb.out_valid = (state_q == LOCK) && owner_req;
        xfer        = arb.out_valid && arb.out_ready;
        arb.pop     = xfer ? gnt_q : '0;
        release_now = xfer && ((|(arb.tail & gnt_q)) || !LOCK_EN);
        ptr_rel     = (sel_q == SEL_F) ? SEL_A : sel_q + SEL_W'(1);
        // The owner being released still shows req for the flit now leaving; mask it out.
        pick_req    = (state_q == LOCK) ? (arb.req & ~gnt_q) : arb.req;
        pick_ptr    = (state_q == LOCK) ? ptr_rel : ptr_q;
    end

    rr_pick6 u_pick (
        .req_i (pick_req),
        .ptr_i (pick_ptr),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    // Next-state: arbitrate from IDLE, or release and re-arbitrate without a bubble in LOCK.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = LOCK;
                    gnt_d   = pick_win;
                    sel_d   = onehot6_to_sel(pick_win);
                end
            end
            LOCK: begin
                if (release_now) begin
                    ptr_d = ptr_rel;
                    if (pick_any) begin
                        gnt_d = pick_win;
                        sel_d = onehot6_to_sel(pick_win);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        sel_d   = SEL_A;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                sel_d   = SEL_A;
            end
        endcase
    end

    // State, grant, select and pointer registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= SEL_A;
            ptr_q   <= PTR_RST;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign arb.gnt  = gnt_q;
    assign arb.sel  = sel_q;
    assign arb.busy = (state_q == LOCK);

endmodule

// File: tb/tb_mux6to1_rr_ctrl.sv
// Scoreboard bench for mux6to1_rr_ctrl: each driven cycle queues its expected outputs,
// which are popped and compared on the following falling edge.
module tb_mux6to1_rr_ctrl;
    import noc_arb_pkg::*;

    typedef struct packed {
        logic [5:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic [5:0] pop;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t  exp_q[$];
    string tag_q[$];

    mux6to1_rr_ctrl_if bus ();

    mux6to1_rr_ctrl #(.LOCK_EN(1'b1), .PTR_INIT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue what the outputs must be.
    task automatic cyc(input string tag, input logic [5:0] r, input logic [5:0] t, input logic rdy,
                       input logic [5:0] eg, input logic [2:0] es, input logic ev,
                       input logic [5:0] ep, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req       = r;
        bus.tail      = t;
        bus.out_ready = rdy;
        e.gnt = eg; e.sel = es; e.valid = ev; e.pop = ep; e.busy = eb;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle_cyc(input string tag, input logic [5:0] r, input logic [5:0] t);
        cyc(tag, r, t, 1'b1, 6'b0, SEL_A, 1'b0, 6'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req = '0; bus.tail = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard consumer: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string tg;
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            check({tg, ".gnt"},   32'(bus.gnt),       32'(e.gnt));
            check({tg, ".sel"},   32'(bus.sel),       32'(e.sel));
            check({tg, ".valid"}, 32'(bus.out_valid), 32'(e.valid));
            check({tg, ".pop"},   32'(bus.pop),       32'(e.pop));
            check({tg, ".busy"},  32'(bus.busy),      32'(e.busy));
        end
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        n_checks = 0; n_fail = 0;
        bus.req = '0; bus.tail = '0; bus.out_ready = 1'b0;

        // 1. Reset values, then an idle stretch.
        #3;
        check("rst.gnt",   32'(bus.gnt),       32'h0);
        check("rst.sel",   32'(bus.sel),       32'h0);
        check("rst.valid", 32'(bus.out_valid), 32'h0);
        check("rst.pop",   32'(bus.pop),       32'h0);
        check("rst.busy",  32'(bus.busy),      32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) idle_cyc("idle", 6'b0, 6'b0);

        // 2. Single requester c; afterwards ptr=3 so d beats everyone from IDLE.
        idle_cyc("t2_req", 6'b000100, 6'b000100);
        cyc("t2_gnt", 6'b000100, 6'b000100, 1, 6'b000100, SEL_C, 1, 6'b000100, 1);
        idle_cyc("t2_idle", 6'b0, 6'b0);
        idle_cyc("t2_all", 6'b111111, 6'b111111);
        cyc("t2_ptr3", 6'b001000, 6'b001000, 1, 6'b001000, SEL_D, 1, 6'b001000, 1);
        idle_cyc("t2_done", 6'b0, 6'b0);

        // 3. Fairness and wrap with all inputs requesting single-flit packets.
        do_reset();
        idle_cyc("t3_req", 6'b111111, 6'b111111);
        for (int i = 0; i < 7; i++) begin
            logic [5:0] g;
            g = 6'b000001 << (i % 6);
            cyc($sformatf("t3_rr%0d", i), 6'b111111, 6'b111111, 1, g, 3'(i % 6), 1, g, 1);
        end
        cyc("t3_next_b", 6'b0, 6'b0, 1, 6'b000010, SEL_B, 0, 6'b0, 1);

        // 4. Four-flit packet on e locks out a, then a gets the next grant.
        do_reset();
        idle_cyc("t4_req", 6'b010000, 6'b0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("t4_body%0d", i), 6'b010001, 6'b0, 1, 6'b010000, SEL_E, 1, 6'b010000, 1);
        cyc("t4_tail", 6'b010001, 6'b010000, 1, 6'b010000, SEL_E, 1, 6'b010000, 1);
        cyc("t4_a", 6'b000001, 6'b000001, 1, 6'b000001, SEL_A, 1, 6'b000001, 1);
        idle_cyc("t4_idle", 6'b0, 6'b0);

        // 5. Backpressure then a mid-packet bubble on owner e (ptr=1 here).
        idle_cyc("t5_req", 6'b010000, 6'b0);
        cyc("t5_flit1", 6'b010000, 6'b0, 1, 6'b010000, SEL_E, 1, 6'b010000, 1);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("t5_stall%0d", i), 6'b010001, 6'b0, 0, 6'b010000, SEL_E, 1, 6'b0, 1);
        for (int i = 0; i < 2; i++)
            cyc($sformatf("t5_bubble%0d", i), 6'b000011, 6'b0, 1, 6'b010000, SEL_E, 0, 6'b0, 1);
        cyc("t5_tail", 6'b010011, 6'b010000, 1, 6'b010000, SEL_E, 1, 6'b010000, 1);
        cyc("t5_wrap_a", 6'b000001, 6'b000001, 1, 6'b000001, SEL_A, 1, 6'b000001, 1);
        idle_cyc("t5_idle", 6'b0, 6'b0);

        // 6. Asynchronous reset while f owns the mux mid-packet.
        idle_cyc("t6_req", 6'b100000, 6'b0);
        cyc("t6_f", 6'b100000, 6'b0, 1, 6'b100000, SEL_F, 1, 6'b100000, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async.gnt",   32'(bus.gnt),       32'h0);
        check("t6_async.sel",   32'(bus.sel),       32'h0);
        check("t6_async.valid", 32'(bus.out_valid), 32'h0);
        check("t6_async.busy",  32'(bus.busy),      32'h0);
        bus.req = '0; bus.tail = '0;
        @(posedge clk); #1; rst_n = 1'b1;
        idle_cyc("t6_post", 6'b100001, 6'b100001);
        cyc("t6_a", 6'b000001, 6'b000001, 1, 6'b000001, SEL_A, 1, 6'b000001, 1);
        idle_cyc("t6_idle", 6'b0, 6'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
